// File: rtl/btn_event_arbiter_pkg.sv
// Shared types and helpers for the button event arbiter.
package btn_event_arbiter_pkg;

  // Arbiter states: waiting for a pending event, or offering one downstream.
  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_t;

  // Width of a channel index for n channels (never narrower than 1 bit).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// One input channel: 2-FF synchronizer, debounce filter and rising-edge detect.
module btn_conditioner #(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic rise
);

  localparam int unsigned CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          stable;
  logic          stable_d;
  logic [CW-1:0] cnt;

  // Two-stage synchronizer for the asynchronous pin level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= in;
      s2 <= s1;
    end
  end

  // Accept a new level only after it has persisted for DEB_CYCLES cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (s2 == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      stable <= s2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Delayed copy of the debounced level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_d <= 1'b0;
    end else begin
      stable_d <= stable;
    end
  end

  // Rising edge of the debounced level; falling edges are ignored.
  assign rise = stable & ~stable_d;

endmodule

// File: rtl/btn_event_arbiter.sv
// Conditions N button inputs, latches presses as pending events and offers
// them one at a time in round-robin order over a valid/ready handshake.
module btn_event_arbiter
  import btn_event_arbiter_pkg::*;
#(
  parameter  int unsigned N          = 4,
  parameter  int unsigned DEB_CYCLES = 16,
  localparam int unsigned IW         = idx_w(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  in,
  output logic          evt_valid,
  output logic [IW-1:0] evt_id,
  input  logic          evt_ready,
  output logic [N-1:0]  evt_drop,
  output logic [N-1:0]  pending
);

  localparam logic [IW-1:0] LAST_ID = IW'(N - 1);

  logic [N-1:0]  rise;
  logic [N-1:0]  clr;
  logic [N-1:0]  pending_d;
  logic [N-1:0]  drop_d;
  logic          hs;
  logic          found;
  logic [IW-1:0] pick;
  logic [IW-1:0] cand;
  arb_state_t    state_q;
  arb_state_t    state_d;
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic          valid_d;
  logic [IW-1:0] id_d;

  // Per-channel synchronizer, debounce and edge detect.
  for (genvar g = 0; g < N; g++) begin : g_cond
    btn_conditioner #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_cond (
      .clk  (clk),
      .rst_n(rst_n),
      .in   (in[g]),
      .rise (rise[g])
    );
  end

  assign hs = evt_valid & evt_ready;

  // Pending flag update: a rise wins over a same-cycle clear; rise on a held flag is a drop.
  always_comb begin
    clr = '0;
    if (hs) begin
      clr[evt_id] = 1'b1;
    end
    pending_d = rise | (pending & ~clr);
    drop_d    = rise & pending & ~clr;
  end

  // Pending flags and registered drop pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      evt_drop <= '0;
    end else begin
      pending  <= pending_d;
      evt_drop <= drop_d;
    end
  end

  // Round-robin search: first pending channel starting at ptr_q.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IW'((32'(ptr_q) + k) % N);
      if (!found && pending[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Arbiter next state and registered offer outputs.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    valid_d = evt_valid;
    id_d    = evt_id;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = OFFER;
          valid_d = 1'b1;
          id_d    = pick;
        end
      end
      OFFER: begin
        if (evt_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
          ptr_d   = (evt_id == LAST_ID) ? '0 : evt_id + IW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // Arbiter state, pointer and offer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      evt_valid <= 1'b0;
      evt_id    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      evt_valid <= valid_d;
      evt_id    <= id_d;
    end
  end

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Bench for btn_event_arbiter: vector table of presses with expected grant
// order, scoreboard queue of expected event ids, and hand-written corner cases.
module tb_btn_event_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] in;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic       evt_ready;
  logic [3:0] evt_drop;
  logic [3:0] pending;

  btn_event_arbiter #(
    .N         (4),
    .DEB_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in),
    .evt_valid(evt_valid),
    .evt_id   (evt_id),
    .evt_ready(evt_ready),
    .evt_drop (evt_drop),
    .pending  (pending)
  );

  typedef struct {
    logic [3:0]      press;
    int              n;
    logic [3:0][1:0] ids;
  } vec_t;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  logic [1:0] exp_q[$];
  int         hs_times[$];
  int         drop_cnt[4] = '{0, 0, 0, 0};
  int         drop_total = 0;
  logic       pv = 1'b0;
  logic       phs = 1'b0;
  logic [1:0] pid = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Scoreboard and protocol monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      pv  = 1'b0;
      phs = 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (evt_drop[i]) begin
          drop_cnt[i]++;
          drop_total++;
        end
      end
      if (pv && !phs) begin
        n_vec++;
        if (!(evt_valid && evt_id == pid)) begin
          n_err++;
          $display("FAIL offer_hold: got valid=%0b id=%0d expected valid=1 id=%0d", evt_valid, evt_id, pid);
        end
      end
      if (evt_valid && evt_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_event: got id %0d expected no event", evt_id);
        end else begin
          logic [1:0] e;
          e = exp_q.pop_front();
          if (evt_id !== e) begin
            n_err++;
            $display("FAIL event_id: got %0d expected %0d at cycle %0d", evt_id, e, cyc);
          end
        end
        hs_times.push_back(cyc);
      end
      pv  = evt_valid;
      pid = evt_id;
      phs = evt_valid && evt_ready;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drain(input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      if (exp_q.size() == 0 && !evt_valid) done = 1'b1;
      else step(1);
    end
    check("drain", 32'(done), 1);
  endtask

  task automatic wait_valid(input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      step(1);
      if (evt_valid) done = 1'b1;
    end
    check("wait_valid", 32'(done), 1);
  endtask

  vec_t tbl[6];

  initial begin
    int  base_hs;
    int  base_drop;
    int  base_d1;
    logic early;

    tbl[0] = '{press: 4'b1111, n: 4, ids: {2'd3, 2'd2, 2'd1, 2'd0}};
    tbl[1] = '{press: 4'b0100, n: 1, ids: {2'd0, 2'd0, 2'd0, 2'd2}};
    tbl[2] = '{press: 4'b0011, n: 2, ids: {2'd0, 2'd0, 2'd1, 2'd0}};
    tbl[3] = '{press: 4'b1010, n: 2, ids: {2'd0, 2'd0, 2'd1, 2'd3}};
    tbl[4] = '{press: 4'b0001, n: 1, ids: {2'd0, 2'd0, 2'd0, 2'd0}};
    tbl[5] = '{press: 4'b1001, n: 2, ids: {2'd0, 2'd0, 2'd0, 2'd3}};

    rst_n     = 1'b0;
    in        = '0;
    evt_ready = 1'b0;
    step(3);
    check("rst_valid", 32'(evt_valid), 0);
    check("rst_id", 32'(evt_id), 0);
    check("rst_drop", 32'(evt_drop), 0);
    check("rst_pending", 32'(pending), 0);
    rst_n = 1'b1;
    step(2);

    // Table: simultaneous presses, expected round-robin grant order.
    for (int v = 0; v < 6; v++) begin
      base_hs   = hs_times.size();
      base_drop = drop_total;
      evt_ready = 1'b1;
      in        = tbl[v].press;
      for (int j = 0; j < tbl[v].n; j++) exp_q.push_back(tbl[v].ids[j]);
      step(8);
      in = '0;
      drain(100);
      step(12);
      check("tbl_pending", 32'(pending), 0);
      check("tbl_no_drop", 32'(drop_total - base_drop), 0);
      check("tbl_grants", 32'(hs_times.size() - base_hs), 32'(tbl[v].n));
      for (int j = 1; j < tbl[v].n; j++) begin
        if (hs_times.size() > base_hs + j)
          check("tbl_bubble", 32'(hs_times[base_hs + j] - hs_times[base_hs + j - 1]), 2);
      end
    end

    // Press-to-offer latency on an idle arbiter.
    base_drop = drop_total;
    in = 4'b0100;
    exp_q.push_back(2'd2);
    early = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      step(1);
      if (evt_valid) early = 1'b1;
    end
    check("lat_early", 32'(early), 0);
    step(1);
    check("lat_valid", 32'(evt_valid), 1);
    check("lat_id", 32'(evt_id), 2);
    drain(50);
    in = '0;
    step(12);
    check("lat_pending", 32'(pending), 0);
    check("lat_no_drop", 32'(drop_total - base_drop), 0);

    // Bounce shorter than the debounce window produces no event.
    base_hs = hs_times.size();
    in = 4'b0001; step(3);
    in = 4'b0000; step(1);
    in = 4'b0001; step(3);
    in = 4'b0000; step(15);
    check("bounce_none", 32'(hs_times.size() - base_hs), 0);
    check("bounce_pending", 32'(pending), 0);
    in = 4'b0001;
    exp_q.push_back(2'd0);
    step(10);
    in = '0;
    drain(50);
    step(12);
    check("bounce_one", 32'(hs_times.size() - base_hs), 1);

    // Second press while the first is still offered is dropped.
    base_hs   = hs_times.size();
    base_d1   = drop_cnt[1];
    base_drop = drop_total;
    evt_ready = 1'b0;
    in = 4'b0010;
    exp_q.push_back(2'd1);
    wait_valid(30);
    check("drop_first_id", 32'(evt_id), 1);
    in = '0;
    step(12);
    in = 4'b0010;
    step(12);
    check("drop_pulse_ch1", 32'(drop_cnt[1] - base_d1), 1);
    check("drop_total", 32'(drop_total - base_drop), 1);
    check("drop_still_valid", 32'(evt_valid), 1);
    check("drop_id_held", 32'(evt_id), 1);
    in = '0;
    evt_ready = 1'b1;
    drain(50);
    step(12);
    check("drop_pending", 32'(pending), 0);
    check("drop_single_hs", 32'(hs_times.size() - base_hs), 1);

    // Rise on channel 2 in the same cycle as its handshake keeps it pending.
    base_drop = drop_total;
    evt_ready = 1'b0;
    in = 4'b0100;
    exp_q.push_back(2'd2);
    wait_valid(30);
    in = '0;
    step(12);
    in = 4'b0100;
    step(6);
    evt_ready = 1'b1;
    exp_q.push_back(2'd2);
    step(1);
    check("same_pending", 32'(pending), 32'h4);
    check("same_valid_low", 32'(evt_valid), 0);
    drain(50);
    in = '0;
    step(12);
    check("same_no_drop", 32'(drop_total - base_drop), 0);
    check("same_pending_end", 32'(pending), 0);

    // Reset during an offer with three channels pending.
    evt_ready = 1'b0;
    in = 4'b1011;
    wait_valid(30);
    step(4);
    check("pre_rst_pending", 32'(pending), 32'hB);
    check("pre_rst_id", 32'(evt_id), 3);
    in = 4'b1000;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(evt_valid), 0);
    check("mid_rst_id", 32'(evt_id), 0);
    check("mid_rst_drop", 32'(evt_drop), 0);
    check("mid_rst_pending", 32'(pending), 0);
    step(2);
    rst_n = 1'b1;
    exp_q.push_back(2'd3);
    early = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      step(1);
      if (evt_valid) early = 1'b1;
    end
    check("post_rst_early", 32'(early), 0);
    step(1);
    check("post_rst_valid", 32'(evt_valid), 1);
    check("post_rst_id", 32'(evt_id), 3);
    evt_ready = 1'b1;
    drain(50);
    in = '0;
    step(12);
    check("post_rst_pending", 32'(pending), 0);

    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/btn_event_arbiter.md
# btn_event_arbiter

Collects N asynchronous push-button/switch inputs, synchronizes and debounces each one, and detects its rising edges. Each detected press is held as a pending event. Pending events are granted one at a time, in round-robin order, to a single downstream consumer over a valid/ready handshake. The block sits between the board I/O pins and the control FSM, so the FSM sees one clean, ordered event per press and never a glitch or double count.

## Interface
Parameters:
- N, 4, number of input channels (2..8)
- DEB_CYCLES, 16, consecutive cycles of a changed synchronized level required before it is accepted (≥2)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in  in  N  raw asynchronous button levels
- evt_valid  out  1  an event is offered
- evt_id  out  $clog2(N)  channel index of the offered event
- evt_ready  in  1  consumer accepts; handshake = evt_valid & evt_ready
- evt_drop  out  N  one-cycle pulse per channel: a press was lost because that channel was already pending
- pending  out  N  current pending flags (debug/status)

## Operation
- Per channel, the synchronizer is 2 flip-flops in → s1 → s2, both reset to 0.
- Debounce uses registers `stable` (reset 0) and counter `cnt` (reset 0, width $clog2(DEB_CYCLES)).
  - If s2 == stable: cnt ← 0.
  - Else if cnt == DEB_CYCLES-1: stable ← s2, cnt ← 0.
  - Else: cnt ← cnt+1.
  - Any single-cycle disagreement with s2 restarts the count.
- Edge detect: rise = stable & ~stable_d, where stable_d is a 1-cycle delayed copy (reset 0). Falling edges are ignored.
- Pending flag per channel (reset 0):
  - Set on rise.
  - Cleared on handshake with evt_id == i.
  - rise and clear on the same channel in the same cycle: flag stays 1 (new event). No drop.
  - rise while the flag is 1 and not being cleared: flag stays 1, evt_drop[i] = 1 for that cycle.
- Arbiter FSM with states IDLE and OFFER, reset to IDLE. Round-robin pointer `ptr` resets to 0.
  - IDLE: if |pending, register evt_id = first set index searching ptr, ptr+1, … mod N. Set evt_valid ← 1 and go to OFFER. Otherwise stay.
  - OFFER: evt_valid = 1 and evt_id is held stable until evt_ready. On handshake: clear pending[evt_id], ptr ← (evt_id+1) mod N, evt_valid ← 0, go to IDLE.
  - An offered event is never withdrawn. New events arriving during OFFER do not change evt_id.
- Reset values: evt_valid 0, evt_id 0, evt_drop 0, pending 0.
- Reset mid-operation discards all pending events and any offer. If an input is still held high after reset, it is debounced again and produces one new event.

## Timing
- Edge 1 is the first edge that samples in[i]=1, with a clean level thereafter:
  - s2 = 1 after edge 2.
  - stable = 1 after edge 2+DEB_CYCLES.
  - pending[i] = 1 after edge 3+DEB_CYCLES.
  - evt_valid = 1 after edge 4+DEB_CYCLES (idle arbiter).
- Handshake at edge k: evt_valid = 0 after edge k. The next event is offered after edge k+1, giving one bubble cycle, so the maximum rate is 1 event per 2 cycles.
- evt_drop is a registered pulse, asserted during the cycle after the rise cycle. It is exactly 1 cycle wide.
- evt_valid/evt_id are registered outputs with no combinational path from evt_ready.

## Structure
- Shared package: the arbiter state encoding (IDLE, OFFER) and the index-width helper constant for $clog2(N).
- Sub-module `btn_conditioner`: holds the synchronizer, debounce counter and edge detect for one channel, with ports clk, rst_n, in, rise. It is instantiated N times by generate.
- The top level holds the pending flags, drop logic, round-robin FSM and pointer.

## Test plan
- N=4, DEB_CYCLES=4, evt_ready=1; hold in[2] high from edge 1 → evt_valid=1 with evt_id=2 after edge 8. After the handshake, pending=0 and evt_drop is never asserted.
- Bounce on in[0] (high for 3 cycles, low 1, high 3, low) → no event. Then hold high for 10 cycles → exactly one event, id 0.
- All four inputs pressed simultaneously, evt_ready=1 → ids 0, 1, 2, 3 in order, each separated by a 1-cycle bubble. Next, with ptr=1 and pending={0,3}, → order 3 then 0.
- evt_ready=0 while evt_valid with id 1; a second press on in[1] completes → evt_drop[1] pulses for 1 cycle, evt_id stays 1, and a single handshake leaves pending[1]=0.
- A rise on channel 2 in the same cycle as its handshake → pending[2] stays 1, no drop, and a second event with id 2 is offered.
- Assert rst_n=0 during OFFER with 3 pending channels → all outputs are 0 immediately. After release with in[3] held high, one event id 3 appears after DEB_CYCLES+4 edges.
